// File: rtl/audio_pkg.sv
// Shared audio constants and helpers for the PDM capture and tone/PWM blocks.
// Also carries the PCM handoff struct used between decimator and loudness detector.
package audio_pkg;
    localparam int SYS_FREQ       = 100_000_000;
    localparam int HALF_DIV       = 20;
    localparam int DECIM          = 64;
    localparam int FRAME_LEN      = 256;
    localparam int THRESHOLD      = 20;
    localparam int HOLDOFF_FRAMES = 4;
    localparam int PCM_W          = 7;
    localparam int LEVEL_W        = 6;

    typedef struct packed {
        logic             valid;
        logic [PCM_W-1:0] sample;
    } pcm_t;

    // Counter width for a range 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/loudness_detector.sv
// Frame-based loudness detector: tracks peak |pcm - DECIM/2| per frame and
// fires a one-cycle flap when the peak crosses the threshold outside holdoff.
module loudness_detector #(
    parameter int DECIM          = audio_pkg::DECIM,
    parameter int FRAME_LEN      = audio_pkg::FRAME_LEN,
    parameter int THRESHOLD      = audio_pkg::THRESHOLD,
    parameter int HOLDOFF_FRAMES = audio_pkg::HOLDOFF_FRAMES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  audio_pkg::pcm_t              pcm,
    output logic [audio_pkg::LEVEL_W-1:0] level,
    output logic                         flap
);
    import audio_pkg::*;

    localparam int FR_W = width_of(FRAME_LEN);
    localparam int HO_W = width_of(HOLDOFF_FRAMES + 1);
    localparam logic [PCM_W-1:0] MID = PCM_W'(DECIM / 2);

    logic [FR_W-1:0]    frame_cnt;
    logic [LEVEL_W-1:0] peak;
    logic [LEVEL_W-1:0] dev;
    logic [LEVEL_W-1:0] peak_nxt;
    logic [HO_W-1:0]    holdoff;

    always_comb begin
        dev      = (pcm.sample >= MID) ? LEVEL_W'(pcm.sample - MID) : LEVEL_W'(MID - pcm.sample);
        peak_nxt = (dev > peak) ? dev : peak;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            peak      <= '0;
            holdoff   <= '0;
            level     <= '0;
            flap      <= 1'b0;
        end else begin
            flap <= 1'b0;
            if (pcm.valid) begin
                if (frame_cnt == FR_W'(FRAME_LEN - 1)) begin
                    frame_cnt <= '0;
                    level     <= peak_nxt;
                    peak      <= '0;
                    // A holdoff that expires on this frame end only arms the next one.
                    if (peak_nxt >= LEVEL_W'(THRESHOLD) && holdoff == '0) begin
                        flap    <= 1'b1;
                        holdoff <= HO_W'(HOLDOFF_FRAMES);
                    end else if (holdoff != '0) begin
                        holdoff <= holdoff - HO_W'(1);
                    end
                end else begin
                    frame_cnt <= frame_cnt + FR_W'(1);
                    peak      <= peak_nxt;
                end
            end
        end
    end
endmodule

// File: rtl/mic_pdm_receiver.sv
// PDM microphone front end: generates micClk, samples the synchronized PDM bit
// at the end of each high phase and boxcar-decimates DECIM bits into a PCM count.
module mic_pdm_receiver #(
    parameter int HALF_DIV       = audio_pkg::HALF_DIV,
    parameter int DECIM          = audio_pkg::DECIM,
    parameter int FRAME_LEN      = audio_pkg::FRAME_LEN,
    parameter int THRESHOLD      = audio_pkg::THRESHOLD,
    parameter int HOLDOFF_FRAMES = audio_pkg::HOLDOFF_FRAMES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          micData,
    output logic                          micClk,
    output logic                          chSel,
    output logic [audio_pkg::PCM_W-1:0]   pcm_sample,
    output logic                          pcm_valid,
    output logic [audio_pkg::LEVEL_W-1:0] level,
    output logic                          flap
);
    import audio_pkg::*;

    localparam int DIV_W = width_of(HALF_DIV);
    localparam int BIT_W = width_of(DECIM);

    logic [1:0]       sync;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [PCM_W-1:0] ones;
    logic             div_wrap;
    logic             sample_pt;
    pcm_t             pcm_bus;

    assign chSel     = 1'b0;
    assign div_wrap  = (div_cnt == DIV_W'(HALF_DIV - 1));
    // Last cycle of the high phase: data has been stable well past the rising edge.
    assign sample_pt = enable && micClk && div_wrap;
    assign pcm_bus   = {pcm_valid, pcm_sample};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync       <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            ones       <= '0;
            micClk     <= 1'b0;
            pcm_sample <= '0;
            pcm_valid  <= 1'b0;
        end else begin
            sync      <= {sync[0], micData};
            pcm_valid <= 1'b0;
            if (!enable) begin
                micClk  <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
                ones    <= '0;
            end else begin
                if (div_wrap) begin
                    div_cnt <= '0;
                    micClk  <= ~micClk;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
                if (sample_pt) begin
                    if (bit_cnt == BIT_W'(DECIM - 1)) begin
                        pcm_sample <= ones + PCM_W'(sync[1]);
                        pcm_valid  <= 1'b1;
                        bit_cnt    <= '0;
                        ones       <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        ones    <= ones + PCM_W'(sync[1]);
                    end
                end
            end
        end
    end

    loudness_detector #(
        .DECIM          (DECIM),
        .FRAME_LEN      (FRAME_LEN),
        .THRESHOLD      (THRESHOLD),
        .HOLDOFF_FRAMES (HOLDOFF_FRAMES)
    ) u_loud (
        .clk   (clk),
        .reset (reset),
        .pcm   (pcm_bus),
        .level (level),
        .flap  (flap)
    );
endmodule

// File: tb/tb_mic_pdm_receiver.sv
// Self-checking bench for mic_pdm_receiver with scaled-down parameters so that
// multi-frame loudness behaviour fits in a short run.
module tb_mic_pdm_receiver;
    localparam int HD = 4;
    localparam int D  = 8;
    localparam int FL = 4;
    localparam int TH = 3;
    localparam int HF = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       micData = 1'b0;
    logic       micClk, chSel, pcm_valid, flap;
    logic [6:0] pcm_sample;
    logic [5:0] level;

    always #5 clk = ~clk;

    mic_pdm_receiver #(
        .HALF_DIV(HD), .DECIM(D), .FRAME_LEN(FL), .THRESHOLD(TH), .HOLDOFF_FRAMES(HF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .micData(micData),
        .micClk(micClk), .chSel(chSel), .pcm_sample(pcm_sample),
        .pcm_valid(pcm_valid), .level(level), .flap(flap)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: collects samples, frame-end level/flap and pulse counts.
    int got_pcm[$];
    int got_level[$];
    int got_flap[$];
    int flap_cnt, pv_cnt, pv_wide;
    bit pv_d;

    always @(negedge clk) begin
        if (!reset) begin
            got_pcm.delete(); got_level.delete(); got_flap.delete();
            flap_cnt = 0; pv_cnt = 0; pv_wide = 0; pv_d = 0;
        end else begin
            if (pv_d && (got_pcm.size() % FL) == 0) begin
                got_level.push_back(int'(level));
                got_flap.push_back(int'(flap));
            end
            if (flap) flap_cnt++;
            if (pcm_valid) begin
                if (pv_d) pv_wide++;
                got_pcm.push_back(int'(pcm_sample));
                pv_cnt++;
            end
            pv_d = pcm_valid;
        end
    end

    // Stimulus stream (one bit per micClk period) and the reference model.
    bit stream[$];
    int exp_pcm[$];
    int exp_level[$];
    int exp_flap[$];

    function automatic void push_byte(input logic [7:0] p);
        for (int b = 0; b < 8; b++) stream.push_back(p[b]);
    endfunction

    function automatic void model();
        int nw, hold, pk, dv, s;
        exp_pcm.delete(); exp_level.delete(); exp_flap.delete();
        nw = stream.size() / D;
        for (int w = 0; w < nw; w++) begin
            s = 0;
            for (int b = 0; b < D; b++) s += int'(stream[w*D + b]);
            exp_pcm.push_back(s);
        end
        hold = 0;
        for (int f = 0; f < nw / FL; f++) begin
            pk = 0;
            for (int j = 0; j < FL; j++) begin
                dv = exp_pcm[f*FL + j] - D/2;
                if (dv < 0) dv = -dv;
                if (dv > pk) pk = dv;
            end
            exp_level.push_back(pk);
            if (pk >= TH && hold == 0) begin
                exp_flap.push_back(1);
                hold = HF;
            end else begin
                exp_flap.push_back(0);
                if (hold > 0) hold--;
            end
        end
    endfunction

    task automatic next_fall(output bit ok);
        bit prev;
        prev = micClk;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (prev && !micClk) begin
                ok = 1;
                break;
            end
            prev = micClk;
        end
    endtask

    task automatic do_reset(input bit first_bit);
        reset = 1'b0;
        enable = 1'b1;
        micData = first_bit;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic play(input string tag);
        bit ok;
        int sum_flap, n;
        do_reset(stream.size() > 0 ? stream[0] : 1'b0);
        for (int i = 0; i < stream.size(); i++) begin
            micData = stream[i];
            next_fall(ok);
            if (!ok) begin
                total++; bad++;
                $display("FAIL %s micClk timeout at bit %0d", tag, i);
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        model();
        check($sformatf("%s pcm count", tag), got_pcm.size(), exp_pcm.size());
        n = (got_pcm.size() < exp_pcm.size()) ? got_pcm.size() : exp_pcm.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s pcm[%0d]", tag, i), got_pcm[i], exp_pcm[i]);
        check($sformatf("%s frame count", tag), got_level.size(), exp_level.size());
        n = (got_level.size() < exp_level.size()) ? got_level.size() : exp_level.size();
        for (int f = 0; f < n; f++) begin
            check($sformatf("%s level[%0d]", tag, f), got_level[f], exp_level[f]);
            check($sformatf("%s flap[%0d]", tag, f), got_flap[f], exp_flap[f]);
        end
        sum_flap = 0;
        foreach (exp_flap[f]) sum_flap += exp_flap[f];
        check($sformatf("%s flap pulses", tag), flap_cnt, sum_flap);
        check($sformatf("%s pcm_valid width", tag), pv_wide, 0);
    endtask

    typedef struct {
        logic [7:0] pat;
        int         exp_pcm;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   n, errs, k;
        bit   ok;
        int   loud_flap[6] = '{1, 0, 0, 0, 0, 1};

        tbl[0] = '{8'hFF, 8}; tbl[1] = '{8'h00, 0}; tbl[2] = '{8'hAA, 4}; tbl[3] = '{8'hF0, 4};
        tbl[4] = '{8'h01, 1}; tbl[5] = '{8'h7F, 7}; tbl[6] = '{8'h0F, 4}; tbl[7] = '{8'h3C, 4};

        // Reset held low with toggling data: everything stays at zero.
        reset = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (4) begin micData = ~micData; @(posedge clk); end
            #1;
            check($sformatf("reset outputs %0d", i),
                  int'({micClk, pcm_valid, flap, pcm_sample, level}), 0);
        end
        check("chSel", int'(chSel), 0);

        // First micClk rise HD cycles after release, then period 2*HD.
        @(negedge clk); reset = 1'b1;
        n = 0;
        while (n < 100) begin @(posedge clk); #1; n++; if (micClk) break; end
        check("first micClk rise", n, HD);
        n = 0;
        while (n < 100) begin @(posedge clk); #1; n++; if (!micClk) break; end
        while (n < 200) begin @(posedge clk); #1; n++; if (micClk) break; end
        check("micClk period", n, 2*HD);

        // Table-driven windows: expected counts are hand-derived constants.
        stream.delete();
        foreach (tbl[i]) push_byte(tbl[i].pat);
        play("table");
        for (int i = 0; i < 8; i++)
            if (i < got_pcm.size()) check($sformatf("table vec %0d", i), got_pcm[i], tbl[i].exp_pcm);
        if (got_level.size() == 2) begin
            check("table level f0", got_level[0], 4);
            check("table flap f0", got_flap[0], 1);
            check("table level f1 at threshold in holdoff", got_level[1], 3);
            check("table flap f1", got_flap[1], 0);
        end

        // Alternating bits per micClk period: centred PCM, no loudness.
        stream.delete();
        for (int i = 0; i < 2*FL*D; i++) stream.push_back(i[0]);
        play("alternate");
        check("alternate pcm", got_pcm.size() > 0 ? got_pcm[0] : -1, D/2);

        // Loud for six frames: flaps only at frames 1 and 6.
        stream.delete();
        for (int i = 0; i < 6*FL*D; i++) stream.push_back(1'b1);
        play("loud");
        for (int f = 0; f < 6; f++)
            if (f < got_flap.size()) check($sformatf("loud flap frame %0d", f+1), got_flap[f], loud_flap[f]);

        // Randomized window densities against the reference model.
        stream.delete();
        for (int w = 0; w < 8*FL; w++) begin
            k = $urandom_range(0, D);
            for (int b = 0; b < D; b++) stream.push_back($urandom_range(0, D-1) < k);
        end
        play("random");

        // Enable dropped mid-window: clock stops, partial window is discarded.
        stream.delete();
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) next_fall(ok);
        @(negedge clk); enable = 1'b0;
        errs = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (micClk || pcm_valid) errs++;
        end
        check("enable low quiet", errs, 0);
        check("enable low no pcm", pv_cnt, 0);
        @(negedge clk); enable = 1'b1;
        n = 0;
        while (n < 200) begin @(posedge clk); #1; n++; if (pcm_valid) break; end
        check("re-enable full window", n, 2*HD*D);
        check("re-enable pcm", int'(pcm_sample), D);

        // Reset mid-frame: outputs clear at once, nothing spurious afterwards.
        do_reset(1'b1);
        for (int i = 0; i < 2*D + D/2; i++) next_fall(ok);
        @(posedge clk); #3; reset = 1'b0; #1;
        check("async reset outputs", int'({micClk, pcm_valid, flap, pcm_sample, level}), 0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        repeat (2*HD*D - 4) @(posedge clk);
        #1;
        check("post-reset pcm_valid", pv_cnt, 0);
        check("post-reset flap", flap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mic_pdm_receiver.md
# mic_pdm_receiver

Capture path for the Nexys A7 on-board PDM microphone, the input-side counterpart of the PWM tone output in the audio controller. Generates the microphone clock, samples the 1-bit PDM stream and decimates it with a boxcar ones-counter into PCM samples. A frame-based loudness detector emits a single-cycle `flap` pulse when the player makes a loud sound. Sits in the IO controller's sound path and feeds game logic.

## Interface
- `HALF_DIV`, 20: system cycles per micClk half-period (100 MHz / 40 = 2.5 MHz micClk).
- `DECIM`, 64: PDM bits per PCM sample (~39 kHz output rate).
- `FRAME_LEN`, 256: PCM samples per loudness frame.
- `THRESHOLD`, 20: minimum peak deviation, in PCM counts, that triggers `flap`.
- `HOLDOFF_FRAMES`, 4: frames after a `flap` during which further flaps are suppressed.
- `clk`  input  1  100 MHz system clock.
- `reset`  input  1  asynchronous, active-low; all state cleared while low.
- `enable`  input  1  capture enable; low stops `micClk` and discards partial windows.
- `micData`  input  1  PDM data from the microphone (asynchronous to `clk`).
- `micClk`  output  1  microphone clock, registered.
- `chSel`  output  1  constant 0 (data valid on micClk rising edge).
- `pcm_sample`  output  7  ones count of the last window, 0..DECIM.
- `pcm_valid`  output  1  one-cycle strobe on each new `pcm_sample`.
- `level`  output  6  peak deviation |pcm-DECIM/2| of the last completed frame, 0..32.
- `flap`  output  1  one-cycle loudness trigger.

## Operation
- Reset values: `micClk`=0, `pcm_sample`=0, `pcm_valid`=0, `level`=0, `flap`=0; all counters and holdoff cleared.
- `micData` passes through a 2-flop synchronizer before use.
- Divider counts 0..HALF_DIV-1, toggling `micClk` on wrap; runs only while `enable`=1. When `enable` falls, `micClk` returns to 0 on the next edge and the divider, bit counter and ones counter clear; frame and holdoff state are kept.
- Sample point: the last cycle of each `micClk` high phase (≥180 ns after rising edge). The synchronized bit is added to the ones counter; the bit counter increments.
- On the DECIM-th sample: `pcm_sample` ← ones+bit, `pcm_valid` pulses, ones and bit counters clear. Width: ones counter 7 bits, no wrap (max 64).
- Deviation = |pcm_sample − DECIM/2|, 6 bits. Frame peak register tracks the maximum over FRAME_LEN samples.
- At frame end: `level` ← peak, peak clears. If peak ≥ THRESHOLD and holdoff=0: `flap` pulses, holdoff ← HOLDOFF_FRAMES. Otherwise holdoff decrements if nonzero (saturates at 0).
- Simultaneous frame end and holdoff reaching zero: the decrement completes this frame; a flap is possible no earlier than the next frame end.

## Timing
- First `micClk` rising edge HALF_DIV cycles after `reset` deasserts (with `enable`=1); period 2·HALF_DIV cycles.
- Sample k of a window is taken at cycle 2·HALF_DIV·k − 1 relative to window start.
- `pcm_valid` registers on the same edge that captures the DECIM-th bit; high exactly 1 cycle; `pcm_sample` holds until the next strobe.
- `flap` and `level` update 1 cycle after the `pcm_valid` that closes a frame; `flap` high 1 cycle.
- Input-to-output latency: 2 synchronizer cycles plus window length.
- `reset` asserted mid-operation: outputs return to reset values asynchronously; no strobe is emitted for the partial window.

## Structure
- `audio_pkg`: default constants (SYS_FREQ, HALF_DIV, DECIM) and a `clog2`-based width helper shared with the tone/PWM blocks.
- Sub-module `loudness_detector`: deviation, frame peak, holdoff and `flap` logic, fed by `pcm_sample`/`pcm_valid`.

## Test plan
- Reset held low, toggle `micData` -> all outputs 0, `micClk` static 0; after release, first `micClk` rise at cycle 20, period 40.
- `micData`=1 constant -> `pcm_valid` every 2560 cycles, `pcm_sample`=64; after 256 samples `level`=32, `flap` pulses once.
- `micData` alternating per micClk period -> `pcm_sample`=32, `level`=0, no `flap`.
- Loud input (all 1s) for 6 consecutive frames -> `flap` at frame 1 and frame 6 only (holdoff 4).
- `enable` dropped mid-window for 500 cycles -> `micClk` low, no `pcm_valid`; after re-enable, next sample needs a full 64 bits.
- `reset` asserted mid-frame -> immediate zero outputs; no spurious `pcm_valid` or `flap` after release.
